// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and helpers for the streaming matrix multiplier
// Purpose: FSM state encoding, width derivation functions and the flat index helper.
// Ports: none (package).
package matmul_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_W  = 3'd1;
  localparam logic [2:0] S_LOAD_X  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_LOAD_W  = S_LOAD_W,
    ST_LOAD_X  = S_LOAD_X,
    ST_COMPUTE = S_COMPUTE,
    ST_EMIT    = S_EMIT
  } state_t;

  function automatic int dim_width(input int max_dim);
    return $clog2(max_dim + 1);
  endfunction

  // Worst case sum of max_dim products of two full-scale operands.
  function automatic int acc_width(input int data_w, input int max_dim);
    return 2 * data_w + $clog2(max_dim);
  endfunction

  function automatic int flat_index(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// rtl/matmul_mac_unit.sv - registered multiply-accumulate with load/accumulate select
// Purpose: acc <= a*b when load, acc <= acc + a*b otherwise, only while en.
// Ports: clk, clear (sync active-high), en, load, a/b (DATA_W operands), acc (ACC_W result).
module mac_unit #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 10
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              en,
  input  logic              load,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;

  assign prod     = a * b;
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= load ? prod_ext : acc + prod_ext;
    end
  end

endmodule

// File: rtl/matmul_stream.sv
// rtl/matmul_stream.sv - streaming W*X matrix multiplier with a single sequential MAC
// Purpose: loads W (row-major) then X (column-major) over data_in, emits W*X row-major.
// Ports: clk, clear (sync active-high); start + row_w/col_w/row_x/col_x job request;
//        in_valid/in_ready/data_in load stream; out_valid/out_ready/out_data/out_row/
//        out_col/out_last result stream; busy, done, err status.
module matmul_stream
  import matmul_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int MAX_DIM = 3,
  parameter int DIM_W   = dim_width(MAX_DIM),
  parameter int ACC_W   = acc_width(DATA_W, MAX_DIM)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [DIM_W-1:0]  row_w,
  input  logic [DIM_W-1:0]  col_w,
  input  logic [DIM_W-1:0]  row_x,
  input  logic [DIM_W-1:0]  col_x,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [DIM_W-1:0]  out_row,
  output logic [DIM_W-1:0]  out_col,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int MEM_D  = MAX_DIM * MAX_DIM;
  localparam int ADDR_W = $clog2(MEM_D + 1);

  state_t            state;
  logic [DIM_W-1:0]  row_w_q, col_w_q, row_x_q, col_x_q;
  logic [DIM_W-1:0]  i, j, k;
  logic [ADDR_W-1:0] cnt, w_last, x_last, w_addr, x_addr;
  logic [DATA_W-1:0] w_mem [MEM_D];
  logic [DATA_W-1:0] x_mem [MEM_D];
  logic              dims_ok, elem_last, k_last, mac_en, mac_load;
  logic [ACC_W-1:0]  acc;

  assign dims_ok = (row_w != '0) && (col_w != '0) && (row_x != '0) && (col_x != '0) &&
                   (int'(row_w) <= MAX_DIM) && (int'(col_w) <= MAX_DIM) &&
                   (int'(row_x) <= MAX_DIM) && (int'(col_x) <= MAX_DIM) &&
                   (col_w == row_x);

  assign w_last = ADDR_W'(int'(row_w_q) * int'(col_w_q) - 1);
  assign x_last = ADDR_W'(int'(row_x_q) * int'(col_x_q) - 1);

  // W is stored row-major and X column-major exactly as they arrive, so the
  // load counter doubles as the write address.
  assign w_addr = ADDR_W'(flat_index(int'(i), int'(k), int'(col_w_q)));
  assign x_addr = ADDR_W'(flat_index(int'(j), int'(k), int'(row_x_q)));

  assign k_last    = (k == col_w_q - DIM_W'(1));
  assign elem_last = (i == row_w_q - DIM_W'(1)) && (j == col_x_q - DIM_W'(1));
  assign mac_en    = (state == ST_COMPUTE);
  assign mac_load  = (k == '0);

  always_ff @(posedge clk) begin
    if (in_valid && in_ready && state == ST_LOAD_W) w_mem[cnt] <= data_in;
    if (in_valid && in_ready && state == ST_LOAD_X) x_mem[cnt] <= data_in;
  end

  mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .clear (clear),
    .en    (mac_en),
    .load  (mac_load),
    .a     (w_mem[w_addr]),
    .b     (x_mem[x_addr]),
    .acc   (acc)
  );

  // acc only moves in COMPUTE, so it is stable for the whole EMIT hold.
  assign out_data = acc;
  assign out_row  = i;
  assign out_col  = j;

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      cnt       <= '0;
      row_w_q   <= '0;
      col_w_q   <= '0;
      row_x_q   <= '0;
      col_x_q   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (dims_ok) begin
              row_w_q  <= row_w;
              col_w_q  <= col_w;
              row_x_q  <= row_x;
              col_x_q  <= col_x;
              cnt      <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              state    <= ST_LOAD_W;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_LOAD_W: begin
          if (in_valid) begin
            if (cnt == w_last) begin
              cnt   <= '0;
              state <= ST_LOAD_X;
            end else begin
              cnt <= cnt + ADDR_W'(1);
            end
          end
        end
        ST_LOAD_X: begin
          if (in_valid) begin
            if (cnt == x_last) begin
              cnt      <= '0;
              in_ready <= 1'b0;
              i        <= '0;
              j        <= '0;
              k        <= '0;
              state    <= ST_COMPUTE;
            end else begin
              cnt <= cnt + ADDR_W'(1);
            end
          end
        end
        ST_COMPUTE: begin
          if (k_last) begin
            out_valid <= 1'b1;
            out_last  <= elem_last;
            state     <= ST_EMIT;
          end else begin
            k <= k + DIM_W'(1);
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            k         <= '0;
            if (elem_last) begin
              i     <= '0;
              j     <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              if (j == col_x_q - DIM_W'(1)) begin
                j <= '0;
                i <= i + DIM_W'(1);
              end else begin
                j <= j + DIM_W'(1);
              end
              state <= ST_COMPUTE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_stream.sv
// tb/tb_matmul_stream.sv - self-checking bench for matmul_stream
module tb_matmul_stream;

  localparam int DATA_W = 4;
  localparam int DIM_W  = 2;
  localparam int ACC_W  = 10;

  logic              clk = 1'b0;
  logic              clear = 1'b1;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  row_w = '0, col_w = '0, row_x = '0, col_x = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] data_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ACC_W-1:0]  out_data;
  logic [DIM_W-1:0]  out_row, out_col;
  logic              out_last, busy, done, err;

  matmul_stream #(.DATA_W(DATA_W), .MAX_DIM(3), .DIM_W(DIM_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .clear(clear), .start(start),
    .row_w(row_w), .col_w(col_w), .row_x(row_x), .col_x(col_x),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int row;
    int col;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   words[$];
  int   wv[9], xv[9], ev[9];
  int   total = 0;
  int   bad = 0;

  task automatic do_start(input int rw, input int cw, input int rx, input int cx);
    @(negedge clk);
    start = 1'b1;
    row_w = DIM_W'(rw); col_w = DIM_W'(cw); row_x = DIM_W'(rx); col_x = DIM_W'(cx);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_words(input string name, input int cnt, input bit toggle);
    int  idx = 0;
    int  guard = 0;
    bit  ph = 1'b0;
    while (idx < cnt && guard < 500) begin
      @(negedge clk);
      guard++;
      if (toggle && ph) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        data_in  = DATA_W'(words[idx]);
      end
      ph = ~ph;
      if (in_valid && in_ready) idx++;
    end
    total++;
    if (idx != cnt) begin
      bad++;
      $display("FAIL %s load timeout: accepted=%0d required=%0d", name, idx, cnt);
    end
  endtask

  task automatic run_job(input string name, input int rw, input int cw, input int rx,
                         input int cx, input bit toggle, input int stall_elem,
                         input int stall_cycles);
    int   n = 0;
    int   guard = 0;
    int   stall = 0;
    bit   lat_done = 1'b0;
    int   n_out;
    exp_t e;
    logic [ACC_W-1:0] hd;
    logic [DIM_W-1:0] hr, hc;
    n_out = rw * cx;
    words.delete();
    for (int a = 0; a < rw * cw; a++) words.push_back(wv[a]);
    for (int a = 0; a < rx * cx; a++) words.push_back(xv[a]);
    for (int a = 0; a < n_out; a++) sb.push_back('{ev[a], a / cx, a % cx, a == n_out - 1});

    do_start(rw, cw, rx, cx);
    total++;
    if ({busy, in_ready} !== 2'b11) begin
      bad++;
      $display("FAIL %s start busy/in_ready: got=%b required=11", name, {busy, in_ready});
    end
    load_words(name, rw * cw + rx * cx, toggle);

    out_ready = 1'b1;
    while (n < n_out && guard < 2000) begin
      @(negedge clk);
      guard++;
      in_valid = 1'b0;
      if (out_valid) begin
        if (!lat_done) begin
          lat_done = 1'b1;
          total++;
          if (guard != cw + 1) begin
            bad++;
            $display("FAIL %s first latency: got=%0d required=%0d", name, guard, cw + 1);
          end
        end
        if (n == stall_elem && stall < stall_cycles) begin
          if (stall == 0) begin
            hd = out_data; hr = out_row; hc = out_col;
          end else begin
            total++;
            if ({out_data, out_row, out_col} !== {hd, hr, hc}) begin
              bad++;
              $display("FAIL %s stall stable: got=%0d,%0d,%0d required=%0d,%0d,%0d",
                       name, out_data, out_row, out_col, hd, hr, hc);
            end
          end
          stall++;
          out_ready = 1'b0;
        end else begin
          out_ready = 1'b1;
          e = sb.pop_front();
          total++;
          if (out_data !== ACC_W'(e.data) || out_row !== DIM_W'(e.row) ||
              out_col !== DIM_W'(e.col) || out_last !== e.last) begin
            bad++;
            $display("FAIL %s elem%0d: got data=%0d row=%0d col=%0d last=%b required data=%0d row=%0d col=%0d last=%b",
                     name, n, out_data, out_row, out_col, out_last, e.data, e.row, e.col, e.last);
          end
          n++;
        end
      end
    end
    total++;
    if (n != n_out) begin
      bad++;
      $display("FAIL %s output timeout: got=%0d required=%0d", name, n, n_out);
      sb.delete();
    end
    @(negedge clk);
    total++;
    if ({done, busy, out_valid} !== 3'b100) begin
      bad++;
      $display("FAIL %s done pulse: got done,busy,valid=%b required=100", name, {done, busy, out_valid});
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL %s done width: got=%b required=0", name, done);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, out_valid, out_last, busy, done, err, out_data, out_row, out_col} !== '0) begin
      bad++;
      $display("FAIL reset outputs: got=%h required=0",
               {in_ready, out_valid, out_last, busy, done, err, out_data, out_row, out_col});
    end
    clear = 1'b0;
  endtask

  task automatic test_1x1();
    wv[0] = 10; xv[0] = 2; ev[0] = 20;
    run_job("1x1", 1, 1, 1, 1, 1'b0, -1, 0);
  endtask

  task automatic test_2x2();
    wv = '{1, 2, 3, 10, 0, 0, 0, 0, 0};
    xv = '{10, 10, 11, 15, 0, 0, 0, 0, 0};
    ev = '{30, 41, 130, 183, 0, 0, 0, 0, 0};
    run_job("2x2", 2, 2, 2, 2, 1'b0, -1, 0);
  endtask

  task automatic test_3x2();
    wv = '{10, 2, 1, 2, 3, 5, 0, 0, 0};
    xv = '{2, 8, 9, 1, 4, 5, 0, 0, 0};
    ev = '{36, 92, 50, 18, 11, 14, 46, 32, 37};
    run_job("3x2x3", 3, 2, 2, 3, 1'b0, -1, 0);
  endtask

  task automatic test_overflow();
    for (int a = 0; a < 9; a++) begin
      wv[a] = 15; xv[a] = 15; ev[a] = 675;
    end
    run_job("3x3max", 3, 3, 3, 3, 1'b0, -1, 0);
  endtask

  task automatic test_backpressure();
    wv = '{1, 2, 3, 10, 0, 0, 0, 0, 0};
    xv = '{10, 10, 11, 15, 0, 0, 0, 0, 0};
    ev = '{30, 41, 130, 183, 0, 0, 0, 0, 0};
    run_job("backpressure", 2, 2, 2, 2, 1'b1, 2, 6);
  endtask

  task automatic test_errors();
    int rw_t[2] = '{1, 0};
    int cw_t[2] = '{2, 2};
    int rx_t[2] = '{3, 2};
    for (int t = 0; t < 2; t++) begin
      do_start(rw_t[t], cw_t[t], rx_t[t], 2);
      total++;
      if ({err, busy, in_ready} !== 3'b100) begin
        bad++;
        $display("FAIL err case%0d pulse: got err,busy,in_ready=%b required=100", t, {err, busy, in_ready});
      end
      @(negedge clk);
      total++;
      if ({err, busy, in_ready} !== 3'b000) begin
        bad++;
        $display("FAIL err case%0d after: got err,busy,in_ready=%b required=000", t, {err, busy, in_ready});
      end
    end
  endtask

  task automatic test_clear_mid_load();
    words = '{1, 2, 3, 10, 10, 10};
    do_start(2, 2, 2, 2);
    load_words("clear_load", 6, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++;
    if ({in_ready, out_valid, out_last, busy, done, err, out_data, out_row, out_col} !== '0) begin
      bad++;
      $display("FAIL clear mid-load outputs: got=%h required=0",
               {in_ready, out_valid, out_last, busy, done, err, out_data, out_row, out_col});
    end
    wv = '{1, 2, 3, 10, 0, 0, 0, 0, 0};
    xv = '{10, 10, 11, 15, 0, 0, 0, 0, 0};
    ev = '{30, 41, 130, 183, 0, 0, 0, 0, 0};
    run_job("after_clear", 2, 2, 2, 2, 1'b0, -1, 0);
  endtask

  initial begin
    test_reset();
    test_1x1();
    test_2x2();
    test_3x2();
    test_overflow();
    test_backpressure();
    test_errors();
    test_clear_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
